imem_dmem_arbiter: RTL
======================

Name: imem_dmem_arbiter

Overview:
- Shares one synchronous single-port 4K-word RAM between the fetch stage (read-only) and the memory stage (load/store).
- Unified instruction/data memory; replaces the separate asynchronous instruction RAM and synchronous data RAM.
- Per-cycle grant; data side has priority; starvation guard protects fetch.
- Read data is returned one cycle after grant, tagged to the requester that owned the slot.

Parameters:
- ADDR_W, 12, word-address width (4096 words).
- DATA_W, 32, data width.
- STARVE_LIMIT, 3, consecutive denied fetch cycles before fetch is forced to win; legal range 1..15.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ce  in  1  clock enable; low = no grants, all state holds
- if_req  in  1  fetch read request, held until granted
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  fetch granted this cycle
- if_rvalid  out  1  if_rdata valid (cycle after if_gnt)
- if_rdata  out  DATA_W  fetched instruction
- d_req  in  1  data request, held until granted
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data granted this cycle
- d_rvalid  out  1  d_rdata valid (cycle after a load grant)
- d_rdata  out  DATA_W  load data
- mem_addr  out  ADDR_W  RAM address
- mem_we  out  1  RAM write enable
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, registered inside the RAM, valid the cycle after the address
- if_wait_cnt  out  CNT_W  cycles with if_req high and if_gnt low
- d_wait_cnt  out  CNT_W  cycles with d_req high and d_gnt low

Behaviour:
- Grant is combinational from the current requests and state, in the same cycle as the request; at most one grant per cycle.
- Priority:
  - force_if = (starve_cnt == STARVE_LIMIT).
  - d_gnt = ce & d_req & ~(force_if & if_req).
  - if_gnt = ce & if_req & ~d_gnt.
- starve_cnt is 4-bit, updated when ce is high:
  - Increments when if_req & ~if_gnt, saturating at STARVE_LIMIT.
  - Clears to 0 when if_gnt or ~if_req.
  - Clears after a forced grant, so fetch cannot win twice in a row by force.
- Memory drive:
  - d_gnt: mem_addr = d_addr, mem_we = d_we, mem_wdata = d_wdata.
  - if_gnt: mem_addr = if_addr, mem_we = 0.
  - No grant: mem_addr = 0, mem_we = 0, mem_wdata = 0.
- Read return: owner register with encodings NONE / IF / DLOAD. It loads IF on if_gnt, DLOAD on d_gnt & ~d_we, otherwise NONE.
  - Stores never produce d_rvalid.
  - if_rvalid = (owner == IF); d_rvalid = (owner == DLOAD).
  - if_rdata = mem_rdata when if_rvalid, else 0; d_rdata likewise.
- ce low:
  - Both grants are 0 and mem_we is 0.
  - owner, starve_cnt and the counters hold.
  - rvalid outputs follow the held owner, matching the RAM output register, which also holds.
- Performance counters increment by 1 when ce is high and their wait condition is true; they saturate at all-ones with no wrap.
- Reset (rst high at a clock edge, overriding ce):
  - owner = NONE, starve_cnt = 0, both counters = 0.
  - Therefore if_rvalid = d_rvalid = 0 and both rdata outputs = 0 in the cycle after reset.
  - A read granted in the reset cycle is discarded, not delivered.
  - Grants are combinational and are not gated by rst.
- Simultaneous requests:
  - Data wins unless force_if is set.
  - A fetch and a store to the same address never both occur in one cycle; a load after a store to the same address sees the new value (RAM is write-first).
- Latency:
  - Grant to rvalid is exactly 1 cycle.
  - A single requester is served every cycle (100% throughput).
  - Under continuous contention fetch is guaranteed 1 grant per STARVE_LIMIT+1 cycles.

Decomposition:
- Shared package `mem_arb_pkg`:
  - owner encoding constants: OWN_NONE=2'd0, OWN_IF=2'd1, OWN_DLOAD=2'd2.
  - ADDR_W/DATA_W defaults.
- One natural sub-module: `sat_counter` (CNT_W-bit saturating incrementer with enable and sync reset), instantiated twice for the wait counters.
- The starvation counter stays inline.

Test Plan:
- Reset with if_req=1, if_addr=5 asserted in the same cycle -> cycle after reset: if_rvalid=0, counters=0; next grant returns mem[5] one cycle later.
- Only if_req, addresses 0,1,2 on consecutive cycles, mem[k]=k+100 -> if_gnt=1 every cycle; if_rvalid with if_rdata 100,101,102 on the following cycles.
- d_req store addr 7 data 0xDEADBEEF, then load addr 7 -> store: mem_we=1, no d_rvalid; load: d_rvalid next cycle with d_rdata=0xDEADBEEF.
- if_req and d_req (loads) both held high for 12 cycles, STARVE_LIMIT=3 -> if_gnt in cycles 4, 8 and 12 only; d_gnt otherwise; if_wait_cnt=9, d_wait_cnt=3.
- ce low for 3 cycles with both requests high -> no grants, mem_we=0, starve_cnt and counters unchanged, rvalid outputs hold their pre-stall values.
- CNT_W=4, fetch starved for 20 cycles -> if_wait_cnt saturates at 15 and does not wrap.

Source files
------------

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared constants for the unified instruction/data memory arbiter:
//          default bus widths and read-return owner encodings.
// Rev    : 1.0  initial release
// ============================================================================
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 12;
  localparam int DATA_W_DEF = 32;

  // Who owns the RAM read data that appears on the next cycle
  localparam logic [1:0] OWN_NONE  = 2'd0;
  localparam logic [1:0] OWN_IF    = 2'd1;
  localparam logic [1:0] OWN_DLOAD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/imem_dmem_arbiter_sat_counter.sv
`default_nettype none
// ============================================================================
// Module : sat_counter
// Brief  : WIDTH-bit incrementer with enable and synchronous reset that
//          sticks at all-ones instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  // Count enabled cycles, holding once every bit is set
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/imem_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : imem_dmem_arbiter
// Brief  : Per-cycle arbiter sharing one synchronous single-port RAM between
//          instruction fetch (read-only) and the data stage (load/store).
//          Data has priority; a starvation counter forces a fetch grant after
//          STARVE_LIMIT consecutive denied fetch cycles. Read data returns one
//          cycle after the grant, routed to whichever side owned that slot.
// Rev    : 1.0  initial release
// ============================================================================
module imem_dmem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 3,   // 1..15, fits the 4-bit starvation counter
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  if_wait_cnt,
  output logic [CNT_W-1:0]  d_wait_cnt
);

  localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

  logic [3:0] r_starve_cnt;
  logic [1:0] r_owner;
  logic       w_force_if;
  logic       w_if_wait;
  logic       w_d_wait;

  // Grant decision: data wins unless fetch has been starved long enough
  always_comb begin
    w_force_if = (r_starve_cnt == c_starve_limit);
    d_gnt      = ce & d_req & ~(w_force_if & if_req);
    if_gnt     = ce & if_req & ~d_gnt;
    w_if_wait  = ce & if_req & ~if_gnt;
    w_d_wait   = ce & d_req & ~d_gnt;
  end

  // Steer the granted requester onto the RAM port; idle bus is all zero
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_addr  = d_addr;
      mem_we    = d_we;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Track consecutive denied fetch cycles; any fetch grant (forced or not)
  // clears it, so a forced win is always followed by a fresh count
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= 4'd0;
    end else if (ce) begin
      if (if_req && !if_gnt) begin
        if (r_starve_cnt != c_starve_limit) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end else begin
        r_starve_cnt <= 4'd0;
      end
    end
  end

  // Remember who owns the RAM output register on the next cycle; holds with
  // ce low because the RAM output register holds too
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= OWN_NONE;
    end else if (ce) begin
      if (if_gnt) begin
        r_owner <= OWN_IF;
      end else if (d_gnt && !d_we) begin
        r_owner <= OWN_DLOAD;
      end else begin
        r_owner <= OWN_NONE;
      end
    end
  end

  // Route returning read data to its owner, zero elsewhere
  always_comb begin
    if_rvalid = (r_owner == OWN_IF);
    d_rvalid  = (r_owner == OWN_DLOAD);
    if_rdata  = if_rvalid ? mem_rdata : '0;
    d_rdata   = d_rvalid  ? mem_rdata : '0;
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_if_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (w_if_wait),
    .count (if_wait_cnt)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_d_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .en    (w_d_wait),
    .count (d_wait_cnt)
  );

endmodule
`default_nettype wire
